// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, fetches over a req/ack handshake and
// presents instruction + PC to decode, with a one-entry skid buffer that
// absorbs a word arriving while decode is stalled.
//
// state | meaning
// IDLE  | after reset, no request outstanding
// REQ   | request to pc_q outstanding, waiting for ack
// SKID  | one fetched word parked in the skid buffer, waiting for stall to drop
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  output logic        inst_req_o,
  output logic [31:0] inst_addr_o,
  input  logic        inst_ack_i,
  input  logic [31:0] inst_rdata_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_valid_o
);

  localparam logic [31:0] PcInit = RESET_PC & 32'hFFFF_FFFC;
  localparam logic [31:0] PcStep = 32'(PC_STEP);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SKID = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic        req_q;
  logic        valid_q;
  logic [31:0] inst_q;
  logic [31:0] id_pc_q;
  logic [31:0] skid_inst_q;
  logic [31:0] skid_pc_q;

  // Fetch FSM, output slot and skid buffer; later assignments in the case
  // override the "slot consumed" clear so a load on the same edge wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= PcInit;
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      inst_q      <= 32'h0;
      id_pc_q     <= 32'h0;
      skid_inst_q <= 32'h0;
      skid_pc_q   <= 32'h0;
    end else begin
      if (valid_q && !stall_i) begin
        valid_q <= 1'b0;
        inst_q  <= 32'h0;
        id_pc_q <= 32'h0;
      end
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          req_q   <= 1'b1;
        end
        REQ: begin
          if (inst_ack_i) begin
            pc_q <= pc_q + PcStep;
            if (!valid_q || !stall_i) begin
              inst_q  <= inst_rdata_i;
              id_pc_q <= pc_q;
              valid_q <= 1'b1;
            end else begin
              skid_inst_q <= inst_rdata_i;
              skid_pc_q   <= pc_q;
              state_q     <= SKID;
              req_q       <= 1'b0;
            end
          end
        end
        SKID: begin
          if (!stall_i) begin
            inst_q  <= skid_inst_q;
            id_pc_q <= skid_pc_q;
            valid_q <= 1'b1;
            state_q <= REQ;
            req_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign inst_req_o  = req_q;
  assign inst_addr_o = {pc_q[31:2], 2'b00};
  assign id_pc_o     = id_pc_q;
  assign id_inst_o   = inst_q;
  assign id_valid_o  = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a memory driver pushes the expected (pc, inst) pair on
// every accepted ack; a negedge monitor pops and compares each newly
// presented instruction, checks bubbles are zero and stalled outputs hold.
module tb_if_stage;

  localparam logic [31:0] RPC_A = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        req;
  logic [31:0] addr, id_pc, id_inst;
  logic        id_valid;

  logic        w_req, w_valid, u_req, u_valid;
  logic [31:0] w_addr, w_pc, w_inst, u_addr, u_pc, u_inst, w_rdata, u_rdata;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;
  item_t exp_q[$];

  logic [31:0] exp_fetch_pc = RPC_A;
  int lat = 1;
  int ws = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RPC_A), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall),
    .inst_req_o(req), .inst_addr_o(addr),
    .inst_ack_i(ack), .inst_rdata_i(rdata),
    .id_pc_o(id_pc), .id_inst_o(id_inst), .id_valid_o(id_valid)
  );

  assign w_rdata = ~w_addr;
  if_stage #(.RESET_PC(32'hFFFF_FFF8), .PC_STEP(4)) dut_wrap (
    .clk(clk), .rst(rst), .stall_i(1'b0),
    .inst_req_o(w_req), .inst_addr_o(w_addr),
    .inst_ack_i(1'b1), .inst_rdata_i(w_rdata),
    .id_pc_o(w_pc), .id_inst_o(w_inst), .id_valid_o(w_valid)
  );

  assign u_rdata = ~u_addr;
  if_stage #(.RESET_PC(32'h0000_0103), .PC_STEP(4)) dut_unal (
    .clk(clk), .rst(rst), .stall_i(1'b0),
    .inst_req_o(u_req), .inst_addr_o(u_addr),
    .inst_ack_i(1'b1), .inst_rdata_i(u_rdata),
    .id_pc_o(u_pc), .id_inst_o(u_inst), .id_valid_o(u_valid)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, req_v);
    end
  endtask

  // One clock: drive memory response for the current request, apply rst and
  // stall, advance past the edge.
  task automatic cycle(input bit do_rst);
    if (req) begin
      check("fetch_addr", addr, exp_fetch_pc);
      if (lat != 0 && ws >= lat - 1) begin
        ack = 1'b1;
        ws  = 0;
        if (do_rst) begin
          rdata = 32'hDEAD_BEEF;
        end else begin
          rdata = memf(exp_fetch_pc);
          exp_q.push_back({exp_fetch_pc, memf(exp_fetch_pc)});
          exp_fetch_pc = exp_fetch_pc + 32'd4;
        end
      end else begin
        ack = 1'b0;
        if (lat != 0) ws++;
      end
    end else begin
      ack   = 1'($urandom_range(0, 1));
      rdata = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
      ws    = 0;
    end
    rst = do_rst;
    @(posedge clk);
    #1;
    if (do_rst) begin
      exp_q.delete();
      exp_fetch_pc = RPC_A;
      ws = 0;
    end
  endtask

  // Monitor: new presentation unless the slot was held by a stall last edge.
  logic        p_valid = 1'b0, p_stall = 1'b0;
  logic [31:0] p_pc = 32'h0, p_inst = 32'h0;
  always @(negedge clk) begin
    item_t it;
    if (rst) begin
      p_valid = 1'b0;
      p_stall = 1'b0;
    end else begin
      if (!id_valid) begin
        check("bubble_inst", id_inst, 32'h0);
        check("bubble_pc", id_pc, 32'h0);
      end else if (p_valid && p_stall) begin
        check("hold_pc", id_pc, p_pc);
        check("hold_inst", id_inst, p_inst);
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_inst: got pc %h inst %h expected none", id_pc, id_inst);
      end else begin
        it = exp_q.pop_front();
        check("id_pc", id_pc, it.pc);
        check("id_inst", id_inst, it.inst);
      end
      p_valid = id_valid;
      p_stall = stall;
      p_pc    = id_pc;
      p_inst  = id_inst;
    end
  end

  initial begin
    int n;
    cycle(1);
    cycle(1);
    check("rst_req", {31'h0, req}, 32'h0);
    check("rst_valid", {31'h0, id_valid}, 32'h0);
    check("rst_inst", id_inst, 32'h0);
    check("rst_pc", id_pc, 32'h0);

    // Reset release, ack every cycle, no stall.
    lat = 1;
    stall = 1'b0;
    cycle(0);
    check("first_req", {31'h0, req}, 32'h1);
    check("first_addr", addr, 32'h0000_0100);
    check("wrap_addr0", w_addr, 32'hFFFF_FFF8);
    check("unal_addr0", u_addr, 32'h0000_0100);
    cycle(0);
    check("first_valid", {31'h0, id_valid}, 32'h1);
    check("first_idpc", id_pc, 32'h0000_0100);
    check("wrap_addr1", w_addr, 32'hFFFF_FFFC);
    cycle(0);
    check("wrap_addr2", w_addr, 32'h0000_0000);
    cycle(0);
    check("wrap_addr3", w_addr, 32'h0000_0004);
    check("wrap_idpc3", w_pc, 32'h0000_0000);
    for (int i = 0; i < 8; i++) begin
      cycle(0);
      check("steady_valid", {31'h0, id_valid}, 32'h1);
    end

    // Three-cycle memory latency.
    lat = 3;
    for (int i = 0; i < 12; i++) cycle(0);

    // Stall for four cycles while valid and an ack arrives.
    lat = 1;
    for (int i = 0; i < 3; i++) cycle(0);
    stall = 1'b1;
    cycle(0);
    check("skid_req_low", {31'h0, req}, 32'h0);
    check("skid_valid", {31'h0, id_valid}, 32'h1);
    for (int i = 0; i < 3; i++) cycle(0);
    stall = 1'b0;
    for (int i = 0; i < 5; i++) cycle(0);

    // Random stall/latency interleaving.
    for (int i = 0; i < 60; i++) begin
      lat = $urandom_range(1, 3);
      stall = 1'($urandom_range(0, 1));
      cycle(0);
    end
    stall = 1'b0;
    lat = 1;

    // Reset while a request to 0x200 is pending, with a stale ack.
    n = 0;
    while (!(req && exp_fetch_pc == 32'h0000_0200) && n < 400) begin
      cycle(0);
      n++;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL reach_0x200: got %h expected 00000200", exp_fetch_pc);
    end
    cycle(1);
    check("mid_rst_req", {31'h0, req}, 32'h0);
    check("mid_rst_valid", {31'h0, id_valid}, 32'h0);
    check("mid_rst_inst", id_inst, 32'h0);
    check("mid_rst_pc", id_pc, 32'h0);
    cycle(0);
    check("restart_addr", addr, 32'h0000_0100);
    for (int i = 0; i < 10; i++) cycle(0);

    // Drain: no further acks, everything pushed must have been presented.
    lat = 0;
    for (int i = 0; i < 4; i++) cycle(0);
    check("drain_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
